// File: rtl/fetch_pq_pkg.sv
// Shared constants for the prefetching fetch unit.
package fetch_pq_pkg;

    localparam logic [31:0] KRV_NOP       = 32'h0000_0013;
    localparam int          FETCH_ADDR_W  = 32;
    localparam int          FETCH_INSTR_W = 32;
    localparam int          FETCH_DEPTH   = 4;
    localparam int          FETCH_MAX_OS  = 2;

    // Width of an occupancy counter that must be able to hold the value depth.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_pq_if.sv
// imem request/response and decode handshake bundle of the fetch unit.
interface fetch_pq_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32
);
    logic                   imem_req_valid;
    logic                   imem_req_ready;
    logic [ADDR_WIDTH-1:0]  imem_req_addr;
    logic                   imem_resp_valid;
    logic [INSTR_WIDTH-1:0] imem_resp_data;
    logic                   if_valid;
    logic                   dec_ready;
    logic [INSTR_WIDTH-1:0] instr_dec;
    logic [ADDR_WIDTH-1:0]  pc_dec;

    modport master (
        output imem_req_valid, imem_req_addr, if_valid, instr_dec, pc_dec,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, dec_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, if_valid, instr_dec, pc_dec,
        output imem_req_ready, imem_resp_valid, imem_resp_data, dec_ready
    );
endinterface

// File: rtl/fetch_pq_fifo.sv
// Synchronous FIFO with flush and occupancy count; head is read from the
// storage registers, so it is zero after reset.
module fetch_pq_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             cpu_clk,
    input  logic             cpu_rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        if (p == LAST) return '0;
        return p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is fine when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Storage, pointers and count; flush wins over push and pop.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= bump(wr_ptr);
            end
            if (do_pop) rd_ptr <= bump(rd_ptr);
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/fetch_pq.sv
// Prefetching instruction fetch unit: keeps up to MAX_OS imem requests in
// flight, buffers responses in a DEPTH-entry {pc, instr} queue and discards
// responses that were in flight when a redirect arrived.
module fetch_pq
    import fetch_pq_pkg::*;
#(
    parameter  int ADDR_WIDTH  = FETCH_ADDR_W,
    parameter  int INSTR_WIDTH = FETCH_INSTR_W,
    parameter  int DEPTH       = FETCH_DEPTH,
    parameter  int MAX_OS      = FETCH_MAX_OS,
    localparam int LW          = level_width(DEPTH)
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rst,
    input  logic [ADDR_WIDTH-1:0] boot_addr,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  halt,
    fetch_pq_if.master            bus,
    output logic                  pc_misaligned,
    output logic [ADDR_WIDTH-1:0] fault_pc,
    output logic [LW-1:0]         q_level
);
    logic [ADDR_WIDTH-1:0]             pc;
    logic [ADDR_WIDTH-1:0]             fl_head;
    logic [ADDR_WIDTH+INSTR_WIDTH-1:0] q_head;
    logic [LW-1:0]                     os_cnt;
    logic [LW-1:0]                     os_nxt;
    logic [LW-1:0]                     drop_cnt;
    logic [LW:0]                       credit;
    logic [$clog2(MAX_OS+1)-1:0]       fl_cnt;
    logic fl_full, fl_empty, q_full, q_empty;
    logic accept, resp_ok, drop_now, q_push, q_pop;

    assign bus.imem_req_addr        = pc;
    assign bus.if_valid             = !q_empty;
    assign {bus.pc_dec, bus.instr_dec} = q_head;
    assign pc_misaligned            = (pc[1:0] != 2'b00) && (os_cnt == '0) && q_empty;
    assign fault_pc                 = pc_misaligned ? pc : '0;

    // Request credit, handshake qualifiers and next outstanding count.
    always_comb begin
        credit = {1'b0, os_cnt} + {1'b0, q_level};
        // Every outstanding request owns a queue slot, so the queue cannot overflow.
        bus.imem_req_valid = !redirect && !halt && (pc[1:0] == 2'b00) &&
                             (os_cnt < LW'(MAX_OS)) && (credit < (LW+1)'(DEPTH));
        accept   = bus.imem_req_valid && bus.imem_req_ready;
        resp_ok  = bus.imem_resp_valid && (os_cnt != '0);
        drop_now = resp_ok && (drop_cnt != '0);
        q_push   = resp_ok && (drop_cnt == '0) && !redirect;
        q_pop    = bus.if_valid && bus.dec_ready && !redirect;
        os_nxt   = os_cnt + LW'(accept) - LW'(resp_ok);
    end

    // Fetch pc, outstanding count and stale-response count.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            pc       <= boot_addr;
            os_cnt   <= '0;
            drop_cnt <= '0;
        end else begin
            if (redirect)    pc <= redirect_pc;
            else if (accept) pc <= pc + ADDR_WIDTH'(4);
            os_cnt <= os_nxt;
            // Whatever is still in flight after a redirect belongs to the old path.
            if (redirect)      drop_cnt <= os_nxt;
            else if (drop_now) drop_cnt <= drop_cnt - 1'b1;
        end
    end

    fetch_pq_fifo #(.WIDTH(ADDR_WIDTH), .DEPTH(MAX_OS)) u_inflight (
        .cpu_clk   (cpu_clk),
        .cpu_rst   (cpu_rst),
        .flush     (1'b0),
        .push      (accept),
        .push_data (pc),
        .pop       (resp_ok),
        .head      (fl_head),
        .count     (fl_cnt),
        .full      (fl_full),
        .empty     (fl_empty)
    );

    fetch_pq_fifo #(.WIDTH(ADDR_WIDTH + INSTR_WIDTH), .DEPTH(DEPTH)) u_queue (
        .cpu_clk   (cpu_clk),
        .cpu_rst   (cpu_rst),
        .flush     (redirect),
        .push      (q_push),
        .push_data ({fl_head, bus.imem_resp_data}),
        .pop       (q_pop),
        .head      (q_head),
        .count     (q_level),
        .full      (q_full),
        .empty     (q_empty)
    );

    a_resp_without_req: assert property (@(posedge cpu_clk) disable iff (cpu_rst)
        !(bus.imem_resp_valid && (os_cnt == '0)));
    a_inflight_count: assert property (@(posedge cpu_clk) disable iff (cpu_rst)
        os_cnt == LW'(fl_cnt));
    a_inflight_bounds: assert property (@(posedge cpu_clk) disable iff (cpu_rst)
        !(accept && fl_full) && !(resp_ok && fl_empty));
    a_queue_overflow: assert property (@(posedge cpu_clk) disable iff (cpu_rst)
        !(q_push && q_full && !q_pop));
endmodule

// File: tb/tb_fetch_pq.sv
module tb_fetch_pq;
    import fetch_pq_pkg::*;

    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic        halt;
        logic        dr;
        logic        ren;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_pc;
        logic [2:0]  e_q;
        logic        e_mis;
        logic [31:0] e_fault;
    } vec_t;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst;
    logic [31:0] boot_addr;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        pc_misaligned;
    logic [31:0] fault_pc;
    logic [2:0]  q_level;

    fetch_pq_if #(.ADDR_WIDTH(32), .INSTR_WIDTH(32)) bus ();

    fetch_pq #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .DEPTH(4), .MAX_OS(2)) dut (
        .cpu_clk       (cpu_clk),
        .cpu_rst       (cpu_rst),
        .boot_addr     (boot_addr),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .halt          (halt),
        .bus           (bus),
        .pc_misaligned (pc_misaligned),
        .fault_pc      (fault_pc),
        .q_level       (q_level)
    );

    always #5 cpu_clk = ~cpu_clk;

    int          n_pass  = 0;
    int          n_total = 0;
    vec_t        vt[$];
    logic [31:0] mq[$];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a + KRV_NOP;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    task automatic add(input logic redir, input logic [31:0] rpc, input logic hlt,
                       input logic dr, input logic ren, input logic e_req,
                       input logic [31:0] e_addr, input logic e_iv, input logic [31:0] e_pc,
                       input logic [2:0] e_q, input logic e_mis, input logic [31:0] e_fault);
        vec_t v;
        v.redir = redir; v.rpc = rpc; v.halt = hlt; v.dr = dr; v.ren = ren;
        v.e_req = e_req; v.e_addr = e_addr; v.e_iv = e_iv; v.e_pc = e_pc;
        v.e_q = e_q; v.e_mis = e_mis; v.e_fault = e_fault;
        vt.push_back(v);
    endtask

    // Drive one cycle from a negedge, check outputs 1 time unit later, then
    // let the imem model record the posedge handshakes (latency >= 1 cycle).
    task automatic apply(input vec_t v, input int idx);
        logic        acc;
        logic        rv;
        logic [31:0] a;
        logic [31:0] gone;
        redirect            = v.redir;
        redirect_pc         = v.rpc;
        halt                = v.halt;
        bus.dec_ready       = v.dr;
        bus.imem_req_ready  = 1'b1;
        bus.imem_resp_valid = v.ren && (mq.size() > 0);
        bus.imem_resp_data  = (mq.size() > 0) ? instr_of(mq[0]) : 32'h0;
        #1;
        chk($sformatf("row%0d req_valid", idx), {31'b0, bus.imem_req_valid}, {31'b0, v.e_req});
        chk($sformatf("row%0d req_addr", idx), bus.imem_req_addr, v.e_addr);
        chk($sformatf("row%0d if_valid", idx), {31'b0, bus.if_valid}, {31'b0, v.e_iv});
        if (v.e_iv) begin
            chk($sformatf("row%0d pc_dec", idx), bus.pc_dec, v.e_pc);
            chk($sformatf("row%0d instr_dec", idx), bus.instr_dec, instr_of(v.e_pc));
        end
        chk($sformatf("row%0d q_level", idx), {29'b0, q_level}, {29'b0, v.e_q});
        chk($sformatf("row%0d pc_misaligned", idx), {31'b0, pc_misaligned}, {31'b0, v.e_mis});
        chk($sformatf("row%0d fault_pc", idx), fault_pc, v.e_fault);
        acc = bus.imem_req_valid && bus.imem_req_ready;
        a   = bus.imem_req_addr;
        rv  = bus.imem_resp_valid;
        @(posedge cpu_clk);
        if (rv) gone = mq.pop_front();
        if (acc) mq.push_back(a);
        @(negedge cpu_clk);
    endtask

    task automatic chk_reset(input string tag, input logic [31:0] boot);
        chk({tag, " req_addr"}, bus.imem_req_addr, boot);
        chk({tag, " if_valid"}, {31'b0, bus.if_valid}, 32'h0);
        chk({tag, " instr_dec"}, bus.instr_dec, 32'h0);
        chk({tag, " pc_dec"}, bus.pc_dec, 32'h0);
        chk({tag, " pc_misaligned"}, {31'b0, pc_misaligned}, 32'h0);
        chk({tag, " fault_pc"}, fault_pc, 32'h0);
        chk({tag, " q_level"}, {29'b0, q_level}, 32'h0);
    endtask

    initial begin
        vec_t v;
        // redir rpc halt dr ren | req addr iv pc q mis fault
        // streaming from boot, zero-latency imem
        add(0, 0, 0, 1, 1,  1, 32'h8000_0000, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 1,  1, 32'h8000_0004, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 1,  1, 32'h8000_0008, 1, 32'h8000_0000, 1, 0, 0);
        add(0, 0, 0, 1, 1,  1, 32'h8000_000C, 1, 32'h8000_0004, 1, 0, 0);
        add(0, 0, 0, 1, 1,  1, 32'h8000_0010, 1, 32'h8000_0008, 1, 0, 0);
        // decode stalls: queue fills to 4, requests stop
        add(0, 0, 0, 0, 1,  1, 32'h8000_0014, 1, 32'h8000_000C, 1, 0, 0);
        add(0, 0, 0, 0, 1,  1, 32'h8000_0018, 1, 32'h8000_000C, 2, 0, 0);
        add(0, 0, 0, 0, 1,  0, 32'h8000_001C, 1, 32'h8000_000C, 3, 0, 0);
        add(0, 0, 0, 0, 1,  0, 32'h8000_001C, 1, 32'h8000_000C, 4, 0, 0);
        add(0, 0, 0, 0, 1,  0, 32'h8000_001C, 1, 32'h8000_000C, 4, 0, 0);
        // release: sequence preserved
        add(0, 0, 0, 1, 1,  0, 32'h8000_001C, 1, 32'h8000_000C, 4, 0, 0);
        add(0, 0, 0, 1, 1,  1, 32'h8000_001C, 1, 32'h8000_0010, 3, 0, 0);
        add(0, 0, 0, 1, 1,  1, 32'h8000_0020, 1, 32'h8000_0014, 2, 0, 0);
        add(0, 0, 0, 1, 1,  1, 32'h8000_0024, 1, 32'h8000_0018, 2, 0, 0);
        add(0, 0, 0, 1, 1,  1, 32'h8000_0028, 1, 32'h8000_001C, 2, 0, 0);
        // two outstanding, redirect with one response in the same cycle
        add(0, 0, 0, 1, 0,  1, 32'h8000_002C, 1, 32'h8000_0020, 2, 0, 0);
        add(1, 32'h100, 0, 1, 1,  0, 32'h8000_0030, 1, 32'h8000_0024, 1, 0, 0);
        add(0, 0, 0, 1, 1,  1, 32'h0000_0100, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 1,  1, 32'h0000_0104, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 1,  1, 32'h0000_0108, 1, 32'h0000_0100, 1, 0, 0);
        // halt with two outstanding
        add(0, 0, 0, 1, 0,  1, 32'h0000_010C, 1, 32'h0000_0104, 1, 0, 0);
        add(0, 0, 1, 0, 1,  0, 32'h0000_0110, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 1,  0, 32'h0000_0110, 1, 32'h0000_0108, 1, 0, 0);
        add(0, 0, 1, 0, 1,  0, 32'h0000_0110, 1, 32'h0000_0108, 2, 0, 0);
        add(0, 0, 0, 1, 1,  1, 32'h0000_0110, 1, 32'h0000_0108, 2, 0, 0);
        add(0, 0, 0, 1, 1,  1, 32'h0000_0114, 1, 32'h0000_010C, 1, 0, 0);
        add(0, 0, 0, 1, 1,  1, 32'h0000_0118, 1, 32'h0000_0110, 1, 0, 0);
        // misaligned redirect, one stale response to drain first
        add(1, 32'h102, 0, 1, 0,  0, 32'h0000_011C, 1, 32'h0000_0114, 1, 0, 0);
        add(0, 0, 0, 1, 0,  0, 32'h0000_0102, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 1,  0, 32'h0000_0102, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 1,  0, 32'h0000_0102, 0, 0, 0, 1, 32'h102);
        add(0, 0, 0, 1, 1,  0, 32'h0000_0102, 0, 0, 0, 1, 32'h102);
        add(1, 32'h200, 0, 1, 1,  0, 32'h0000_0102, 0, 0, 0, 1, 32'h102);
        add(0, 0, 0, 1, 1,  1, 32'h0000_0200, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 1,  1, 32'h0000_0204, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 1,  1, 32'h0000_0208, 1, 32'h0000_0200, 1, 0, 0);
        // address wrap at the top of the space
        add(1, 32'hFFFF_FFF8, 0, 1, 0,  0, 32'h0000_020C, 1, 32'h0000_0204, 1, 0, 0);
        add(0, 0, 0, 1, 1,  1, 32'hFFFF_FFF8, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 1,  1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 1,  1, 32'h0000_0000, 1, 32'hFFFF_FFF8, 1, 0, 0);
        add(0, 0, 0, 1, 1,  1, 32'h0000_0004, 1, 32'hFFFF_FFFC, 1, 0, 0);
        add(0, 0, 0, 1, 1,  1, 32'h0000_0008, 1, 32'h0000_0000, 1, 0, 0);

        cpu_rst             = 1'b1;
        boot_addr           = 32'h8000_0000;
        redirect            = 1'b0;
        redirect_pc         = 32'h0;
        halt                = 1'b0;
        bus.dec_ready       = 1'b1;
        bus.imem_req_ready  = 1'b1;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0;
        @(negedge cpu_clk);
        @(negedge cpu_clk);
        chk_reset("reset", 32'h8000_0000);
        cpu_rst = 1'b0;

        for (int i = 0; i < vt.size(); i++) begin
            v = vt[i];
            apply(v, i);
        end

        // Asynchronous reset in the middle of streaming, new boot address.
        boot_addr = 32'h4000_0000;
        #2;
        cpu_rst             = 1'b1;
        bus.imem_resp_valid = 1'b0;
        mq.delete();
        #1;
        chk_reset("midreset", 32'h4000_0000);
        @(negedge cpu_clk);
        cpu_rst = 1'b0;
        add(0, 0, 0, 1, 1,  1, 32'h4000_0000, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 1,  1, 32'h4000_0004, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 1,  1, 32'h4000_0008, 1, 32'h4000_0000, 1, 0, 0);
        for (int i = vt.size() - 3; i < vt.size(); i++) begin
            v = vt[i];
            apply(v, i);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
